// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache controller.
// Victim selection lives here so the controller and any future users agree on it.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2,
    FETCH  = 2'd3
  } icache_state_t;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  localparam int COUNT_W = 32;

  // Prefer an empty way before evicting the LRU way.
  function automatic logic pick_victim(input logic [1:0] valid, input logic lru);
    logic way;
    if (!valid[0]) begin
      way = WAY0;
    end else if (!valid[1]) begin
      way = WAY1;
    end else begin
      way = lru;
    end
    return way;
  endfunction

endpackage

// File: rtl/icache_perf_cnt.sv
// Saturating hit/miss counter pair for the instruction-cache controller.
// Only instantiated when ICACHE_PERF_CNT_EN is defined.
module icache_perf_cnt
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hit_inc,
  input  logic               miss_inc,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [1:0] inc;
  assign inc = {miss_inc, hit_inc};

  // Index 0 counts hits, index 1 counts misses; both stick at all-ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [COUNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign hit_count  = g_cnt[0].cnt_reg;
  assign miss_count = g_cnt[1].cnt_reg;

endmodule

// File: rtl/icache_control.sv
// Two-way instruction-cache controller: lookup, hit response, miss line fill.
// Define ICACHE_PERF_CNT_EN to add the hit_count/miss_count ports.
module icache_control
  import icache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  output logic       mem_resp,
  input  logic [1:0] hit_datapath,
  input  logic [1:0] valid_out,
  input  logic       lru_output,
  output logic       pmem_read,
  input  logic       pmem_resp,
  output logic       write_enable_0,
  output logic       write_enable_1,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic       load_lru,
  output logic       set_lru
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
`endif
);

  icache_state_t state_reg, state_next;
  logic          victim_reg, victim_next;
  logic          fill;
  logic [1:0]    way_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      victim_reg <= WAY0;
    end else begin
      state_reg  <= state_next;
      victim_reg <= victim_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    victim_next = victim_reg;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    fill        = 1'b0;
    load_lru    = 1'b0;
    set_lru     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_read) state_next = LOOKUP;
      end
      LOOKUP: begin
        state_next = mem_read ? CHECK : IDLE;
      end
      CHECK: begin
        if (!mem_read) begin
          state_next = IDLE;
        end else if (hit_datapath != 2'b00) begin
          // A dual hit is resolved to way 0, so way 0 only needs hit_datapath[0].
          mem_resp   = 1'b1;
          load_lru   = 1'b1;
          set_lru    = hit_datapath[0] ? ~WAY0 : ~WAY1;
          state_next = IDLE;
        end else begin
          victim_next = pick_victim(valid_out, lru_output);
          state_next  = FETCH;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill       = 1'b1;
          load_lru   = 1'b1;
          set_lru    = ~victim_reg;
          mem_resp   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    assign way_fill[gi] = fill && (victim_reg == 1'(gi));
  end

  assign write_enable_0 = way_fill[0];
  assign write_enable_1 = way_fill[1];
  assign load_tag       = way_fill;
  assign load_valid     = way_fill;

`ifdef ICACHE_PERF_CNT_EN
  logic hit_inc, miss_inc;
  assign hit_inc  = (state_reg == CHECK) && mem_read && (hit_datapath != 2'b00);
  assign miss_inc = (state_reg == CHECK) && mem_read && (hit_datapath == 2'b00);

  icache_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .hit_inc    (hit_inc),
    .miss_inc   (miss_inc),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_icache_control.sv
// Bench for icache_control: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a request-level model.
module tb_icache_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_read = 1'b0;
  logic [1:0] hit_datapath = 2'b00;
  logic [1:0] valid_out = 2'b00;
  logic       lru_output = 1'b0;
  logic       pmem_resp = 1'b0;
  logic       mem_resp, pmem_read, write_enable_0, write_enable_1, load_lru, set_lru;
  logic [1:0] load_tag, load_valid;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad = 0;

  // Request-level model: how many cycles the current request has been open,
  // whether it has turned into a line fetch, and which way that fetch fills.
  int m_age = 0;
  bit m_fetch = 1'b0;
  bit m_victim = 1'b0;
  int m_hits = 0;
  int m_misses = 0;

  icache_control dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_resp       (mem_resp),
    .hit_datapath   (hit_datapath),
    .valid_out      (valid_out),
    .lru_output     (lru_output),
    .pmem_read      (pmem_read),
    .pmem_resp      (pmem_resp),
    .write_enable_0 (write_enable_0),
    .write_enable_1 (write_enable_1),
    .load_tag       (load_tag),
    .load_valid     (load_valid),
    .load_lru       (load_lru),
    .set_lru        (set_lru)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin : compare
    int n_age, n_hits, n_misses;
    bit n_fetch, n_victim;
    bit e_resp, e_pread, e_lru, e_set;
    logic [1:0] e_fill;
    logic [9:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      n_age = m_age; n_fetch = m_fetch; n_victim = m_victim;
      n_hits = m_hits; n_misses = m_misses;
      e_resp = 0; e_pread = 0; e_lru = 0; e_set = 0; e_fill = 2'b00;
      if (!rst) begin
        n_age = 0; n_fetch = 0; n_victim = 0; n_hits = 0; n_misses = 0;
      end else if (m_fetch) begin
        e_pread = 1;
        if (pmem_resp) begin
          e_fill = m_victim ? 2'b10 : 2'b01;
          e_lru = 1; e_set = !m_victim; e_resp = 1;
          n_age = 0; n_fetch = 0;
        end
      end else if (m_age == 0) begin
        if (mem_read) n_age = 1;
      end else if (m_age == 1) begin
        n_age = mem_read ? 2 : 0;
      end else begin
        n_age = 0;
        if (mem_read && hit_datapath != 2'b00) begin
          e_resp = 1; e_lru = 1;
          e_set = (hit_datapath == 2'b10) ? 1'b0 : 1'b1;
          n_hits = m_hits + 1;
        end else if (mem_read) begin
          n_misses = m_misses + 1;
          n_fetch = 1;
          if (valid_out[0] == 0) n_victim = 0;
          else if (valid_out[1] == 0) n_victim = 1;
          else n_victim = lru_output;
        end
      end
      exp_v = {e_resp, e_pread, e_fill[0], e_fill[1], e_fill, e_fill, e_lru, e_set};
      got_v = {mem_resp, pmem_read, write_enable_0, write_enable_1, load_tag, load_valid,
               load_lru, set_lru};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got=%b want=%b", $time, got_v, exp_v);
      end
`ifdef ICACHE_PERF_CNT_EN
      chk("hit_count_model", hit_count, rst ? 32'(m_hits) : 32'd0);
      chk("miss_count_model", miss_count, rst ? 32'(m_misses) : 32'd0);
`endif
      @(posedge clk);
      m_age = n_age; m_fetch = n_fetch; m_victim = n_victim;
      m_hits = n_hits; m_misses = n_misses;
    end
  end

  initial begin : stimulus
    logic [5:0] r;
    tick();
    @(negedge clk);
    chk("reset_outputs", {mem_resp, pmem_read, write_enable_0, write_enable_1, load_tag,
                          load_valid, load_lru, set_lru}, 0);
    tick();
    rst = 1'b1;

    // Cold miss, memory answers in fetch cycle 4.
    tick(); mem_read = 1; hit_datapath = 2'b00; valid_out = 2'b00; lru_output = 0;
    @(negedge clk); chk("cold_idle_resp", mem_resp, 0);
    tick(); tick();
    @(negedge clk); chk("cold_check_pread", pmem_read, 0);
    tick();
    @(negedge clk); chk("cold_fetch1_pread", pmem_read, 1);
    tick(); tick(); tick(); pmem_resp = 1;
    @(negedge clk);
    chk("cold_fill", {write_enable_0, write_enable_1, load_tag, load_valid, set_lru, mem_resp,
                      pmem_read}, 9'b1_0_01_01_1_1_1);
    tick(); mem_read = 0; pmem_resp = 0;
    @(negedge clk); chk("cold_after_resp", mem_resp, 0);

    // Hit on way 1.
    tick(); mem_read = 1; hit_datapath = 2'b10;
    tick();
    @(negedge clk); chk("hit1_lookup_resp", mem_resp, 0);
    tick();
    @(negedge clk); chk("hit1_check", {mem_resp, load_lru, set_lru, pmem_read}, 4'b1100);
    tick(); mem_read = 0; hit_datapath = 2'b00;

    // Full set, LRU says way 1; victim must stay latched while inputs move.
    tick(); mem_read = 1; valid_out = 2'b11; lru_output = 1;
    tick(); tick();
    tick(); valid_out = 2'b00; lru_output = 0; pmem_resp = 1;
    @(negedge clk);
    chk("full_fill", {write_enable_0, write_enable_1, load_tag, load_valid, set_lru, mem_resp},
        8'b0_1_10_10_0_1);
    tick(); mem_read = 0; pmem_resp = 0;

    // Back-to-back hits on way 0 with mem_read held.
    tick(); mem_read = 1; hit_datapath = 2'b01;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r[k] = mem_resp;
      if (k < 5) tick();
    end
    chk("b2b_resp_pattern", 32'(r), 32'(6'b100100));
    tick(); mem_read = 0;

    // Illegal dual hit resolves to way 0.
    tick(); mem_read = 1; hit_datapath = 2'b11;
    tick(); tick();
    @(negedge clk); chk("dual_hit", {mem_resp, load_lru, set_lru}, 3'b111);
    tick(); mem_read = 0;

    tick(); mem_read = 1; hit_datapath = 2'b01;
    tick(); tick();
    @(negedge clk); chk("hit0_check", {mem_resp, set_lru}, 2'b11);
    tick(); mem_read = 0; hit_datapath = 2'b00;
`ifdef ICACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_count_5", hit_count, 32'd5);
    chk("miss_count_2", miss_count, 32'd2);
`endif

    // Reset in fetch cycle 2 kills the fetch at once.
    tick(); mem_read = 1; valid_out = 2'b01;
    tick(); tick(); tick(); tick();
    #2 rst = 0; mem_read = 0;
    @(negedge clk);
    chk("rst_fetch_pread", pmem_read, 0);
    chk("rst_fetch_resp", mem_resp, 0);
    tick(); rst = 1; pmem_resp = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {mem_resp, pmem_read, write_enable_0, write_enable_1, load_tag,
                             load_valid, load_lru}, 0);
      tick();
    end
    pmem_resp = 0;

    // Randomized traffic, including aborted requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (mem_read) mem_read = ($urandom_range(0, 9) != 0);
      else mem_read = 1'($urandom_range(0, 1));
      hit_datapath = 2'($urandom_range(0, 3));
      valid_out    = 2'($urandom_range(0, 3));
      lru_output   = 1'($urandom_range(0, 1));
      pmem_resp    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 0;
        tick();
        rst = 1;
      end
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
